// File: rtl/spi_slave_frame_ctrl_pkg.sv
// rtl/spi_slave_frame_ctrl_pkg.sv - shared state encoding, status bit indices and fill default
package spi_slave_frame_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int STAT_FRAME_DONE  = 0;
    localparam int STAT_RX_OVERRUN  = 1;
    localparam int STAT_TX_UNDERRUN = 2;
    localparam int STAT_ABORT       = 3;

    // Underrun fill is all ones; replicated to the character width by the top.
    localparam logic FILL_BIT = 1'b1;

endpackage

// File: rtl/spi_slave_sync_fifo.sv
// rtl/spi_slave_sync_fifo.sv - first-word-fall-through FIFO with wrap-bit full/empty
module spi_slave_sync_fifo #(
    parameter int CHAR_NBITS = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [CHAR_NBITS-1:0] push_data,
    input  logic                  pop,
    output logic [CHAR_NBITS-1:0] head,
    output logic                  full,
    output logic                  empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [AW:0]           wr_ptr_q, wr_ptr_d;
    logic [AW:0]           rd_ptr_q, rd_ptr_d;
    logic [CHAR_NBITS-1:0] mem_q [FIFO_DEPTH];
    logic [CHAR_NBITS-1:0] mem_d [FIFO_DEPTH];
    logic                  push_ok;
    logic                  pop_ok;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    // A pop frees the slot in the same cycle, so a full FIFO still accepts a push.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (push_ok) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/spi_slave_frame_ctrl.sv
// rtl/spi_slave_frame_ctrl.sv - SPI slave frame controller; SPI_SLAVE_FRAME_CNT_EN adds a per-frame character counter
module spi_slave_frame_ctrl
    import spi_slave_frame_ctrl_pkg::*;
#(
    parameter int                    CHAR_NBITS = 32,
    parameter int                    FIFO_DEPTH = 4,
    parameter logic [CHAR_NBITS-1:0] FILL_CHAR  = {CHAR_NBITS{FILL_BIT}}
) (
    input  logic                  S_SYSCLK,
    input  logic                  S_RESET,
    input  logic                  CFG_ENABLE,
    input  logic                  CFG_CPOL,
    input  logic                  CFG_CPHA,
    input  logic                  CFG_REV,
    input  logic [3:0]            CFG_CHAR_LEN,
    input  logic [CHAR_NBITS-1:0] TX_DATA,
    input  logic                  TX_VALID,
    output logic                  TX_READY,
    output logic [CHAR_NBITS-1:0] RX_DATA,
    output logic                  RX_VALID,
    input  logic                  RX_READY,
    output logic [3:0]            STAT,
    input  logic [3:0]            STAT_CLR,
    input  logic [3:0]            IRQ_MASK,
    output logic                  IRQ,
    input  logic                  SPI_CS,
    output logic                  C_ENABLE,
    output logic                  C_CPOL,
    output logic                  C_CPHA,
    output logic                  C_REV,
    output logic [3:0]            C_CHAR_LEN,
    output logic [CHAR_NBITS-1:0] C_WCHAR,
    input  logic [CHAR_NBITS-1:0] C_RCHAR,
    input  logic                  C_CHAR_DONE,
    output logic [15:0]           FRAME_CHARS
);

    state_e                state_q, state_d;
    logic                  loaded_q, loaded_d;
    logic [1:0]            cs_sync_q, cs_sync_d;
    logic                  cs_prev_q, cs_prev_d;
    logic [1:0]            done_sync_q, done_sync_d;
    logic                  done_prev_q, done_prev_d;
    logic                  char_ev_q, char_ev_d;
    logic                  c_enable_q, c_enable_d;
    logic                  c_cpol_q, c_cpol_d;
    logic                  c_cpha_q, c_cpha_d;
    logic                  c_rev_q, c_rev_d;
    logic [3:0]            c_char_len_q, c_char_len_d;
    logic [CHAR_NBITS-1:0] c_wchar_q, c_wchar_d;
    logic [3:0]            stat_q, stat_d;
    logic                  irq_q, irq_d;
    logic [3:0]            stat_set;
    logic                  frame_start, frame_end;
    logic                  tx_push, tx_pop, tx_full, tx_empty;
    logic [CHAR_NBITS-1:0] tx_head;
    logic                  rx_push, rx_pop, rx_full, rx_empty;

    spi_slave_sync_fifo #(.CHAR_NBITS(CHAR_NBITS), .FIFO_DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk       (S_SYSCLK),
        .rst       (S_RESET),
        .push      (tx_push),
        .push_data (TX_DATA),
        .pop       (tx_pop),
        .head      (tx_head),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    spi_slave_sync_fifo #(.CHAR_NBITS(CHAR_NBITS), .FIFO_DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk       (S_SYSCLK),
        .rst       (S_RESET),
        .push      (rx_push),
        .push_data (C_RCHAR),
        .pop       (rx_pop),
        .head      (RX_DATA),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    assign TX_READY   = !tx_full;
    assign RX_VALID   = !rx_empty;
    assign tx_push    = TX_VALID && !tx_full;
    assign rx_pop     = RX_READY && !rx_empty;
    assign STAT       = stat_q;
    assign IRQ        = irq_q;
    assign C_ENABLE   = c_enable_q;
    assign C_CPOL     = c_cpol_q;
    assign C_CPHA     = c_cpha_q;
    assign C_REV      = c_rev_q;
    assign C_CHAR_LEN = c_char_len_q;
    assign C_WCHAR    = c_wchar_q;

    // Chip select is low active: a falling synced edge opens a frame.
    assign frame_start = cs_prev_q && !cs_sync_q[1];
    assign frame_end   = !cs_prev_q && cs_sync_q[1];

    always_comb begin
        cs_sync_d   = {cs_sync_q[0], SPI_CS};
        cs_prev_d   = cs_sync_q[1];
        done_sync_d = {done_sync_q[0], C_CHAR_DONE};
        done_prev_d = done_sync_q[1];
        char_ev_d   = done_sync_q[1] && !done_prev_q;
    end

    always_comb begin
        state_d      = state_q;
        loaded_d     = loaded_q;
        c_enable_d   = c_enable_q;
        c_cpol_d     = c_cpol_q;
        c_cpha_d     = c_cpha_q;
        c_rev_d      = c_rev_q;
        c_char_len_d = c_char_len_q;
        c_wchar_d    = c_wchar_q;
        stat_set     = '0;
        tx_pop       = 1'b0;
        rx_push      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                c_enable_d = 1'b0;
                loaded_d   = 1'b0;
                if (CFG_ENABLE) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (!CFG_ENABLE) begin
                    state_d    = ST_IDLE;
                    c_enable_d = 1'b0;
                    loaded_d   = 1'b0;
                end else begin
                    // Configuration and first character are captured once per arming.
                    if (!loaded_q) begin
                        c_cpol_d     = CFG_CPOL;
                        c_cpha_d     = CFG_CPHA;
                        c_rev_d      = CFG_REV;
                        c_char_len_d = CFG_CHAR_LEN;
                        tx_pop       = 1'b1;
                        c_wchar_d    = tx_empty ? FILL_CHAR : tx_head;
                        c_enable_d   = 1'b1;
                        loaded_d     = 1'b1;
                    end
                    if (frame_start) begin
                        state_d = ST_ACTIVE;
                    end
                end
            end
            ST_ACTIVE: begin
                if (!CFG_ENABLE) begin
                    state_d                = ST_IDLE;
                    c_enable_d             = 1'b0;
                    loaded_d               = 1'b0;
                    stat_set[STAT_ABORT]   = 1'b1;
                end else begin
                    if (char_ev_q) begin
                        rx_push = 1'b1;
                        if (rx_full && !rx_pop) begin
                            stat_set[STAT_RX_OVERRUN] = 1'b1;
                        end
                        tx_pop = 1'b1;
                        if (tx_empty) begin
                            c_wchar_d                  = FILL_CHAR;
                            stat_set[STAT_TX_UNDERRUN] = 1'b1;
                        end else begin
                            c_wchar_d = tx_head;
                        end
                    end
                    if (frame_end) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                stat_set[STAT_FRAME_DONE] = 1'b1;
                loaded_d                  = 1'b0;
                if (CFG_ENABLE) begin
                    state_d = ST_ARMED;
                end else begin
                    state_d    = ST_IDLE;
                    c_enable_d = 1'b0;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                c_enable_d = 1'b0;
                loaded_d   = 1'b0;
            end
        endcase
        stat_d = (stat_q & ~STAT_CLR) | stat_set;
        irq_d  = |(stat_q & IRQ_MASK);
    end

    always_ff @(posedge S_SYSCLK or posedge S_RESET) begin
        if (S_RESET) begin
            state_q      <= ST_IDLE;
            loaded_q     <= 1'b0;
            cs_sync_q    <= 2'b11;
            cs_prev_q    <= 1'b1;
            done_sync_q  <= 2'b00;
            done_prev_q  <= 1'b0;
            char_ev_q    <= 1'b0;
            c_enable_q   <= 1'b0;
            c_cpol_q     <= 1'b0;
            c_cpha_q     <= 1'b0;
            c_rev_q      <= 1'b0;
            c_char_len_q <= 4'd0;
            c_wchar_q    <= FILL_CHAR;
            stat_q       <= 4'd0;
            irq_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            loaded_q     <= loaded_d;
            cs_sync_q    <= cs_sync_d;
            cs_prev_q    <= cs_prev_d;
            done_sync_q  <= done_sync_d;
            done_prev_q  <= done_prev_d;
            char_ev_q    <= char_ev_d;
            c_enable_q   <= c_enable_d;
            c_cpol_q     <= c_cpol_d;
            c_cpha_q     <= c_cpha_d;
            c_rev_q      <= c_rev_d;
            c_char_len_q <= c_char_len_d;
            c_wchar_q    <= c_wchar_d;
            stat_q       <= stat_d;
            irq_q        <= irq_d;
        end
    end

`ifdef SPI_SLAVE_FRAME_CNT_EN
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] frame_chars_q, frame_chars_d;

    always_comb begin
        cnt_d         = cnt_q;
        frame_chars_d = frame_chars_q;
        if (frame_start) begin
            cnt_d = 16'd0;
        end else if (state_q == ST_ACTIVE && char_ev_q && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
        if (state_q == ST_ACTIVE && CFG_ENABLE && frame_end) begin
            frame_chars_d = cnt_d;
        end
    end

    always_ff @(posedge S_SYSCLK or posedge S_RESET) begin
        if (S_RESET) begin
            cnt_q         <= 16'd0;
            frame_chars_q <= 16'd0;
        end else begin
            cnt_q         <= cnt_d;
            frame_chars_q <= frame_chars_d;
        end
    end

    assign FRAME_CHARS = frame_chars_q;
`else
    assign FRAME_CHARS = 16'd0;
`endif

endmodule
